// File: rtl/enemy_formation_mover.sv
// Shared formation driver for a row of enemies: frame-tick divider, four-phase
// swing, descending vertical offset and per-enemy alive tracking with kills.
module enemy_formation_mover #(
  parameter int N_ENEMY = 8,
  parameter int WIDTH = 10,
  parameter logic [WIDTH-1:0] NONE = {WIDTH{1'b1}},
  parameter int BASE_X = 100,
  parameter int SPACING = 40,
  parameter int STEP = 1,
  parameter int PHASE_STEPS = 16,
  parameter int TICK_DIV = 4,
  parameter int DROP = 8
) (
  input  logic                                              i_Clk,
  input  logic                                              i_Reset,
  input  logic                                              i_FrameTick,
  input  logic                                              i_Enable,
  input  logic                                              i_KillValid,
  input  logic [((N_ENEMY > 1) ? $clog2(N_ENEMY) : 1)-1:0]  i_KillIndex,
  output logic [N_ENEMY-1:0]                                o_EnemyState,
  output logic [N_ENEMY*WIDTH-1:0]                          o_EnemyHorizontalPosition,
  output logic [WIDTH-1:0]                                  o_EnemyVerticalOffset,
  output logic [1:0]                                        o_PhaseState,
  output logic                                              o_AllDead,
  output logic                                              o_Wrap
);

  localparam int KIDX_W = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = (PHASE_STEPS > 1) ? $clog2(PHASE_STEPS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PHASE_STEPS - 1);
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [WIDTH:0] DROP_EXT = (WIDTH+1)'(DROP);
  localparam logic [WIDTH:0] VERT_MAX = {1'b0, NONE - {{(WIDTH-1){1'b0}}, 1'b1}};

  typedef enum logic [1:0] {
    PH_LEFT_OUT   = 2'b00,
    PH_RIGHT_BACK = 2'b01,
    PH_RIGHT_OUT  = 2'b10,
    PH_LEFT_BACK  = 2'b11
  } phase_t;

  logic [N_ENEMY-1:0] alive_r, aliveNext_s, killMask_s;
  logic [WIDTH-1:0]   offset_r, offsetNext_s;
  phase_t             phase_r, phaseNext_s;
  logic [STEP_W-1:0]  step_r, stepNext_s;
  logic [TICK_W-1:0]  tick_r, tickNext_s;
  logic [WIDTH-1:0]   vertical_r, verticalNext_s;
  logic               wrap_r, wrapNext_s;
  logic               allDead_s, countTick_s, moveEvent_s;
  logic [WIDTH:0]     verticalSum_s;

  assign allDead_s = ~|alive_r;
  assign countTick_s = i_FrameTick & i_Enable & ~allDead_s;
  assign verticalSum_s = {1'b0, vertical_r} + DROP_EXT;

  // Next-state logic: divider, swing phase machine, descent and kills.
  always_comb begin
    tickNext_s = tick_r;
    moveEvent_s = 1'b0;
    offsetNext_s = offset_r;
    phaseNext_s = phase_r;
    stepNext_s = step_r;
    verticalNext_s = vertical_r;
    wrapNext_s = 1'b0;
    killMask_s = '0;

    if (countTick_s) begin
      if (tick_r == TICK_LAST) begin
        tickNext_s = '0;
        moveEvent_s = 1'b1;
      end else begin
        tickNext_s = tick_r + {{(TICK_W-1){1'b0}}, 1'b1};
      end
    end else begin
      tickNext_s = tick_r;
    end

    if (moveEvent_s) begin
      case (phase_r)
        PH_LEFT_OUT, PH_LEFT_BACK:   offsetNext_s = offset_r - STEP_V;
        PH_RIGHT_BACK, PH_RIGHT_OUT: offsetNext_s = offset_r + STEP_V;
        default:                     offsetNext_s = offset_r;
      endcase
      if (step_r == STEP_LAST) begin
        stepNext_s = '0;
        case (phase_r)
          PH_LEFT_OUT:   phaseNext_s = PH_RIGHT_BACK;
          PH_RIGHT_BACK: phaseNext_s = PH_RIGHT_OUT;
          PH_RIGHT_OUT:  phaseNext_s = PH_LEFT_BACK;
          PH_LEFT_BACK: begin
            phaseNext_s = PH_LEFT_OUT;
            wrapNext_s = 1'b1;
            // Descent saturates one below NONE so it never aliases the dead code.
            if (verticalSum_s > VERT_MAX) begin
              verticalNext_s = VERT_MAX[WIDTH-1:0];
            end else begin
              verticalNext_s = verticalSum_s[WIDTH-1:0];
            end
          end
          default:       phaseNext_s = PH_LEFT_OUT;
        endcase
      end else begin
        stepNext_s = step_r + {{(STEP_W-1){1'b0}}, 1'b1};
      end
    end else begin
      offsetNext_s = offset_r;
    end

    for (int i = 0; i < N_ENEMY; i++) begin
      killMask_s[i] = i_KillValid & (i_KillIndex == KIDX_W'(i));
    end
    aliveNext_s = alive_r & ~killMask_s;
  end

  // Formation state registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      alive_r <= {N_ENEMY{1'b1}};
      offset_r <= '0;
      phase_r <= PH_LEFT_OUT;
      step_r <= '0;
      tick_r <= '0;
      vertical_r <= '0;
      wrap_r <= 1'b0;
    end else begin
      alive_r <= aliveNext_s;
      offset_r <= offsetNext_s;
      phase_r <= phaseNext_s;
      step_r <= stepNext_s;
      tick_r <= tickNext_s;
      vertical_r <= verticalNext_s;
      wrap_r <= wrapNext_s;
    end
  end

  for (genvar g = 0; g < N_ENEMY; g++) begin : gPos
    localparam logic [WIDTH-1:0] HOME = WIDTH'(BASE_X + g * SPACING);
    assign o_EnemyHorizontalPosition[g*WIDTH +: WIDTH] = alive_r[g] ? (HOME + offset_r) : NONE;
  end

  assign o_EnemyState = alive_r;
  assign o_EnemyVerticalOffset = vertical_r;
  assign o_PhaseState = phase_r;
  assign o_AllDead = allDead_s;
  assign o_Wrap = wrap_r;

endmodule

// File: tb/tb_enemy_formation_mover.sv
// Bench for enemy_formation_mover: directed plan steps plus random traffic on an
// 8-enemy and a 6-enemy instance, both checked every cycle against a move-count model.
module tb_enemy_formation_mover;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ft, en, kv;
  logic [2:0] ki;

  logic [7:0]  state8;
  logic [79:0] hpos8;
  logic [9:0]  vert8;
  logic [1:0]  phase8;
  logic        allDead8, wrap8;
  logic [5:0]  state6;
  logic [59:0] hpos6;
  logic [9:0]  vert6;
  logic [1:0]  phase6;
  logic        allDead6, wrap6;

  enemy_formation_mover dut8 (
    .i_Clk(clk), .i_Reset(rst), .i_FrameTick(ft), .i_Enable(en),
    .i_KillValid(kv), .i_KillIndex(ki),
    .o_EnemyState(state8), .o_EnemyHorizontalPosition(hpos8),
    .o_EnemyVerticalOffset(vert8), .o_PhaseState(phase8),
    .o_AllDead(allDead8), .o_Wrap(wrap8)
  );

  enemy_formation_mover #(.N_ENEMY(6)) dut6 (
    .i_Clk(clk), .i_Reset(rst), .i_FrameTick(ft), .i_Enable(en),
    .i_KillValid(kv), .i_KillIndex(ki),
    .o_EnemyState(state6), .o_EnemyHorizontalPosition(hpos6),
    .o_EnemyVerticalOffset(vert6), .o_PhaseState(phase6),
    .o_AllDead(allDead6), .o_Wrap(wrap6)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: formation state follows from the count of qualifying ticks.
  int q[2];
  bit aliveM[2][8];
  bit wrapM[2];

  function automatic int nE(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  function automatic bit deadM(input int d);
    for (int i = 0; i < nE(d); i++) if (aliveM[d][i]) return 1'b0;
    return 1'b1;
  endfunction

  // Offset is a triangle wave over a 64-move cycle: down 16, up 32, down 16.
  function automatic int offOf(input int m);
    int c;
    c = m % 64;
    if (c < 16) return -c;
    else if (c < 48) return c - 32;
    else return 64 - c;
  endfunction

  function automatic int expX(input int d, input int i);
    if (!aliveM[d][i]) return 1023;
    return (100 + i * 40 + offOf(q[d] / 4)) & 1023;
  endfunction

  function automatic int expVert(input int d);
    int v;
    v = 8 * ((q[d] / 4) / 64);
    return (v > 1022) ? 1022 : v;
  endfunction

  task automatic modelUpdate();
    for (int d = 0; d < 2; d++) begin
      wrapM[d] = 1'b0;
      if (rst) begin
        q[d] = 0;
        for (int i = 0; i < 8; i++) aliveM[d][i] = (i < nE(d));
      end else begin
        if (ft && en && !deadM(d)) begin
          q[d]++;
          if ((q[d] % 4 == 0) && ((q[d] / 4) % 64 == 0)) wrapM[d] = 1'b1;
        end
        if (kv && (int'(ki) < nE(d))) aliveM[d][ki] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    logic [31:0] st;
    for (int d = 0; d < 2; d++) begin
      st = '0;
      for (int i = 0; i < nE(d); i++) begin
        st[i] = aliveM[d][i];
        chk($sformatf("d%0d_x%0d", d, i),
            (d == 0) ? 32'(hpos8[i*10 +: 10]) : 32'(hpos6[i*10 +: 10]), expX(d, i));
      end
      chk($sformatf("d%0d_state", d), (d == 0) ? 32'(state8) : 32'(state6), st);
      chk($sformatf("d%0d_vert", d), (d == 0) ? 32'(vert8) : 32'(vert6), expVert(d));
      chk($sformatf("d%0d_phase", d), (d == 0) ? 32'(phase8) : 32'(phase6), ((q[d] / 4) / 16) % 4);
      chk($sformatf("d%0d_alldead", d), (d == 0) ? 32'(allDead8) : 32'(allDead6), 32'(deadM(d)));
      chk($sformatf("d%0d_wrap", d), (d == 0) ? 32'(wrap8) : 32'(wrap6), 32'(wrapM[d]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    checkAll();
  endtask

  int wraps;

  initial begin
    rst = 1'b1; ft = 1'b0; en = 1'b1; kv = 1'b0; ki = 3'd0;
    step(); step();
    chk("rst_x0", 32'(hpos8[9:0]), 100);
    chk("rst_x7", 32'(hpos8[79:70]), 380);
    chk("rst_state", 32'(state8), 32'hFF);
    rst = 1'b0;

    ft = 1'b1;
    repeat (3) step();
    chk("div_3ticks_x0", 32'(hpos8[9:0]), 100);
    step();
    chk("div_4ticks_x0", 32'(hpos8[9:0]), 99);
    en = 1'b0;
    repeat (10) step();
    chk("div_disabled_x0", 32'(hpos8[9:0]), 99);
    en = 1'b1;

    wraps = 0;
    for (int t = 0; t < 252; t++) begin
      step();
      if (wrap8) wraps++;
      if (t == 59) chk("swing16_x0", 32'(hpos8[9:0]), 84);
      if (t == 123) chk("swing32_x0", 32'(hpos8[9:0]), 100);
      if (t == 187) chk("swing48_x0", 32'(hpos8[9:0]), 116);
    end
    chk("swing_wraps", wraps, 1);
    chk("swing_x0", 32'(hpos8[9:0]), 100);
    chk("swing_vert", 32'(vert8), 8);
    chk("swing_phase", 32'(phase8), 0);

    ft = 1'b0; kv = 1'b1; ki = 3'd3;
    step();
    chk("kill3_x3", 32'(hpos8[39:30]), 32'h3FF);
    ki = 3'd7;
    step();
    chk("kill7_n6_state", 32'(state6), 32'b110111);
    kv = 1'b0; ft = 1'b1;
    repeat (3) step();
    kv = 1'b1; ki = 3'd2;
    step();
    chk("killmove_x2", 32'(hpos8[29:20]), 32'h3FF);
    chk("killmove_x0", 32'(hpos8[9:0]), 99);
    kv = 1'b0;

    rst = 1'b1; step(); rst = 1'b0;
    for (int t = 0; t < 662; t++) begin
      kv = (t == 100 || t == 400);
      ki = (t == 100) ? 3'd1 : 3'd5;
      step();
    end
    kv = 1'b0;
    chk("mid_phase", 32'(phase8), 2);
    chk("mid_vert", 32'(vert8), 16);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_state", 32'(state8), 32'hFF);
    chk("midrst_vert", 32'(vert8), 0);

    kv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ki = 3'(i);
      step();
    end
    kv = 1'b0;
    repeat (20) step();
    chk("alldead8", 32'(allDead8), 1);
    chk("alldead6", 32'(allDead6), 1);

    rst = 1'b1; step(); rst = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      ft = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      kv = ($urandom_range(0, 15) == 0);
      ki = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
